// File: rtl/memory_pkg.sv
// ============================================================================
// Module      : memory_pkg
// Description : Shared types and constants for the 48-bit ledger memory
//               responder (state encodings, slot geometry, merge helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_pkg;

  localparam int SLOT_WIDTH = 16;
  localparam int NUM_SLOTS  = 3;
  localparam int WORD_WIDTH = 48;

  localparam logic ACCESS_FULL   = 1'b0;
  localparam logic ACCESS_MASKED = 1'b1;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WRITE_WAIT = 2'b01,
    READ_WAIT  = 2'b10
  } state_t;

  // Replace only the slots whose mask bit is set; other slots keep old_word.
  function automatic logic [WORD_WIDTH-1:0] merge_slots(
    input logic [WORD_WIDTH-1:0] old_word,
    input logic [WORD_WIDTH-1:0] new_word,
    input logic [NUM_SLOTS-1:0]  mask
  );
    logic [WORD_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (mask[i]) begin
        result[i*SLOT_WIDTH +: SLOT_WIDTH] = new_word[i*SLOT_WIDTH +: SLOT_WIDTH];
      end
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_responder_rise_detect.sv
// ============================================================================
// Module      : rise_detect
// Description : Rising-edge detector; remembers the previous level in a
//               register and flags a low-to-high transition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
  input  logic clock,
  input  logic resetn,
  input  logic level,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= level;
    end
  end

  assign rise = level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/memory_responder.sv
// ============================================================================
// Module      : memory_responder
// Description : Memory-side responder holding a 48-bit word as three 16-bit
//               slots; fixed-latency writes (full/masked) and reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_responder
  import memory_pkg::*;
#(
  parameter int                    LATENCY    = 4,
  parameter logic [WORD_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  write_enable,
  input  logic                  access_type,
  input  logic [NUM_SLOTS-1:0]  slot_mask,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  read_req,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  write_ack,
  output logic                  busy
);

  localparam logic [2:0] c_LAST = 3'(LATENCY - 1);

  state_t                r_state;
  logic [2:0]            r_counter;
  logic                  r_pending_read;
  logic [WORD_WIDTH-1:0] r_mem;
  logic [WORD_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_write_ack;

  logic w_write_rise;
  logic w_read_rise;
  logic w_done;

  rise_detect u_write_rise (
    .clock  (clock),
    .resetn (resetn),
    .level  (write_enable),
    .rise   (w_write_rise)
  );

  rise_detect u_read_rise (
    .clock  (clock),
    .resetn (resetn),
    .level  (read_req),
    .rise   (w_read_rise)
  );

  assign w_done = (r_counter == c_LAST);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_counter      <= 3'd0;
      r_pending_read <= 1'b0;
      r_mem          <= INIT_VALUE;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_write_ack    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_write_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_counter <= 3'd0;
          if (w_write_rise) begin
            r_state        <= WRITE_WAIT;
            r_pending_read <= w_read_rise;
          end else if (w_read_rise) begin
            r_state <= READ_WAIT;
          end
        end

        WRITE_WAIT: begin
          if (w_done) begin
            r_counter <= 3'd0;
            // Operands are taken at commit time; a dropped level aborts.
            if (write_enable) begin
              r_mem       <= (access_type == ACCESS_FULL) ? data_in
                                                          : merge_slots(r_mem, data_in, slot_mask);
              r_write_ack <= 1'b1;
            end
            if (r_pending_read || w_read_rise) begin
              r_state        <= READ_WAIT;
              r_pending_read <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_counter <= r_counter + 3'd1;
            if (w_read_rise) begin
              r_pending_read <= 1'b1;
            end
          end
        end

        READ_WAIT: begin
          if (w_done) begin
            r_counter    <= 3'd0;
            r_data_out   <= r_mem;
            r_data_valid <= 1'b1;
            // A read queued during this read is served back-to-back.
            if (r_pending_read || w_read_rise) begin
              r_state        <= READ_WAIT;
              r_pending_read <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_counter <= r_counter + 3'd1;
            if (w_read_rise) begin
              r_pending_read <= 1'b1;
            end
          end
        end

        default: begin
          r_state        <= IDLE;
          r_counter      <= 3'd0;
          r_pending_read <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign write_ack  = r_write_ack;
  assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
// ============================================================================
// Module      : tb_memory_responder
// Description : Directed, table-driven self-checking bench for memory_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_responder;
  import memory_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic        write_enable;
  logic        access_type;
  logic [2:0]  slot_mask;
  logic [47:0] data_in;
  logic        read_req;
  logic [47:0] data_out;
  logic        data_valid;
  logic        write_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  memory_responder #(.LATENCY(4), .INIT_VALUE(48'h0)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .write_enable (write_enable),
    .access_type  (access_type),
    .slot_mask    (slot_mask),
    .data_in      (data_in),
    .read_req     (read_req),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .write_ack    (write_ack),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [47:0] preload;
    logic        at;
    logic [2:0]  mask;
    logic [47:0] wdata;
    logic [47:0] expect_word;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Raise the requested levels at a negedge, keep them for 'hold' cycles,
  // and record when pulses appear. Cycle 0 is the edge-detecting posedge.
  task automatic run_access(
    input  logic        we,
    input  logic        rr,
    input  logic [47:0] wdata,
    input  logic        at,
    input  logic [2:0]  mask,
    input  int          hold,
    output int          ack_cycle,
    output int          ack_count,
    output int          valid_cycle,
    output int          valid_count,
    output logic [47:0] rdata,
    output int          busy_cycles,
    output int          overlap
  );
    ack_cycle = -1; ack_count = 0; valid_cycle = -1; valid_count = 0;
    rdata = 'x; busy_cycles = 0; overlap = 0;
    @(negedge clock);
    write_enable = we; read_req = rr;
    data_in = wdata; access_type = at; slot_mask = mask;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (c == hold - 1) begin
        write_enable = 1'b0;
        read_req     = 1'b0;
      end
      if (busy) busy_cycles++;
      if (write_ack && data_valid) overlap++;
      if (write_ack) begin
        ack_count++;
        if (ack_cycle < 0) ack_cycle = c;
      end
      if (data_valid) begin
        valid_count++;
        if (valid_cycle < 0) begin
          valid_cycle = c;
          rdata = data_out;
        end
      end
    end
  endtask

  initial begin
    int          ac, an, vc, vn, bc, ov;
    logic [47:0] rd;

    vecs[0] = '{48'h1111_2222_3333, ACCESS_MASKED, 3'b010, 48'hAAAA_BBBB_CCCC, 48'h1111_BBBB_3333};
    vecs[1] = '{48'h1111_2222_3333, ACCESS_FULL,   3'b010, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC};
    vecs[2] = '{48'h1111_2222_3333, ACCESS_MASKED, 3'b101, 48'hAAAA_BBBB_CCCC, 48'hAAAA_2222_CCCC};
    vecs[3] = '{48'h1111_2222_3333, ACCESS_MASKED, 3'b000, 48'hAAAA_BBBB_CCCC, 48'h1111_2222_3333};
    vecs[4] = '{48'h1111_2222_3333, ACCESS_MASKED, 3'b111, 48'hAAAA_BBBB_CCCC, 48'hAAAA_BBBB_CCCC};
    vecs[5] = '{48'h5555_6666_7777, ACCESS_MASKED, 3'b001, 48'hDEAD_BEEF_F00D, 48'h5555_6666_F00D};

    resetn = 1'b0; write_enable = 1'b0; read_req = 1'b0;
    access_type = 1'b0; slot_mask = 3'b000; data_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_data_out",   data_out,          48'h0);
    check("reset_data_valid", 48'(data_valid),   48'h0);
    check("reset_write_ack",  48'(write_ack),    48'h0);
    check("reset_busy",       48'(busy),         48'h0);
    resetn = 1'b1;

    // Read of the reset contents, read_req held 8 cycles.
    run_access(1'b0, 1'b1, '0, 1'b0, 3'b000, 8, ac, an, vc, vn, rd, bc, ov);
    check("init_read_valid_cycle", 48'(vc), 48'd4);
    check("init_read_valid_count", 48'(vn), 48'd1);
    check("init_read_data",        rd,      48'h0);
    check("init_read_busy_cycles", 48'(bc), 48'd4);

    // Full write held 8 cycles: single ack at cycle 4, then readback.
    run_access(1'b1, 1'b0, 48'h1234_5678_9ABC, ACCESS_FULL, 3'b000, 8, ac, an, vc, vn, rd, bc, ov);
    check("full_write_ack_cycle", 48'(ac), 48'd4);
    check("full_write_ack_count", 48'(an), 48'd1);
    run_access(1'b0, 1'b1, '0, 1'b0, 3'b000, 8, ac, an, vc, vn, rd, bc, ov);
    check("full_write_readback", rd, 48'h1234_5678_9ABC);

    // Table: preload, write (full or masked), read back.
    for (int i = 0; i < 6; i++) begin
      run_access(1'b1, 1'b0, vecs[i].preload, ACCESS_FULL, 3'b000, 8, ac, an, vc, vn, rd, bc, ov);
      check($sformatf("vec%0d_preload_ack", i), 48'(ac), 48'd4);
      run_access(1'b1, 1'b0, vecs[i].wdata, vecs[i].at, vecs[i].mask, 8, ac, an, vc, vn, rd, bc, ov);
      check($sformatf("vec%0d_write_ack", i), 48'(ac), 48'd4);
      run_access(1'b0, 1'b1, '0, 1'b0, 3'b000, 8, ac, an, vc, vn, rd, bc, ov);
      check($sformatf("vec%0d_read_cycle", i), 48'(vc), 48'd4);
      check($sformatf("vec%0d_read_data", i), rd, vecs[i].expect_word);
    end

    // Aborted write: level dropped after 2 cycles.
    run_access(1'b1, 1'b0, 48'h1111_2222_3333, ACCESS_FULL, 3'b000, 8, ac, an, vc, vn, rd, bc, ov);
    run_access(1'b1, 1'b0, 48'h9999_9999_9999, ACCESS_FULL, 3'b000, 2, ac, an, vc, vn, rd, bc, ov);
    check("abort_ack_count",   48'(an), 48'd0);
    check("abort_busy_cycles", 48'(bc), 48'd4);
    run_access(1'b0, 1'b1, '0, 1'b0, 3'b000, 8, ac, an, vc, vn, rd, bc, ov);
    check("abort_mem_unchanged", rd, 48'h1111_2222_3333);

    // Simultaneous write and read edges.
    run_access(1'b1, 1'b1, 48'hFFFF_0000_FFFF, ACCESS_FULL, 3'b000, 10, ac, an, vc, vn, rd, bc, ov);
    check("simul_ack_cycle",   48'(ac), 48'd4);
    check("simul_valid_cycle", 48'(vc), 48'd8);
    check("simul_read_data",   rd,      48'hFFFF_0000_FFFF);
    check("simul_busy_cycles", 48'(bc), 48'd8);
    check("simul_pulse_overlap", 48'(ov), 48'd0);

    // Reset asserted at cycle 2 of WRITE_WAIT.
    @(negedge clock);
    write_enable = 1'b1; data_in = 48'hABCD_ABCD_ABCD; access_type = ACCESS_FULL;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    resetn = 1'b0;
    @(posedge clock); @(negedge clock);
    check("midreset_busy", 48'(busy),      48'h0);
    check("midreset_ack",  48'(write_ack), 48'h0);
    resetn = 1'b1; write_enable = 1'b0;
    an = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); @(negedge clock);
      if (write_ack) an++;
    end
    check("midreset_no_late_ack", 48'(an), 48'd0);
    run_access(1'b0, 1'b1, '0, 1'b0, 3'b000, 8, ac, an, vc, vn, rd, bc, ov);
    check("midreset_mem_init", rd, 48'h0);
    check("midreset_read_cycle", 48'(vc), 48'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
